// File: rtl/reg_file.sv
// -----------------------------------------------------------------------------
// reg_file -- MIPS general-purpose register file
//
// Purpose:
//   Register file for the single-cycle CPU. Two combinational read ports feed
//   the ALU (rd1 -> srcA, rd2 -> srcB mux). One synchronous write port takes
//   the writeback result. A third read-only debug port exposes any register
//   without touching the datapath. Register 0 always reads zero.
//
// Optional feature (compile-time macro):
//   REGFILE_BYPASS_EN -- when defined, rd1/rd2 forward wd3 in the same cycle
//   as a matching write (write-first). dbg_data is never forwarded. When
//   undefined, reads return the stored value only (read-old).
//
// Ports:
//   clk       in   1       clock; writes on rising edge
//   rst       in   1       asynchronous reset, active-high; clears all entries
//   we3       in   1       write enable
//   a3        in   ADDR_W  write address
//   wd3       in   DATA_W  write data
//   a1        in   ADDR_W  read address, port 1 (rs)
//   a2        in   ADDR_W  read address, port 2 (rt)
//   rd1       out  DATA_W  read data, port 1
//   rd2       out  DATA_W  read data, port 2
//   dbg_addr  in   ADDR_W  debug read address
//   dbg_data  out  DATA_W  debug read data
// -----------------------------------------------------------------------------
module reg_file #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we3,
    input  logic [ADDR_W-1:0] a3,
    input  logic [DATA_W-1:0] wd3,
    input  logic [ADDR_W-1:0] a1,
    input  logic [ADDR_W-1:0] a2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    localparam int DEPTH = 2 ** ADDR_W;

    // Entry 0 is never written and is masked on read, so it reduces to a
    // constant zero.
    logic [DATA_W-1:0] r_regs [0:DEPTH-1];

    logic              w_wr_en;
    logic [DATA_W-1:0] w_rd1;
    logic [DATA_W-1:0] w_rd2;
    logic [DATA_W-1:0] w_dbg;

    // Stored value of one entry; zero for register 0 and while reset is held,
    // so no output ever depends on an uninitialised flop.
    function automatic logic [DATA_W-1:0] read_entry(input logic [ADDR_W-1:0] addr);
        logic [DATA_W-1:0] val;
        if (rst || (addr == {ADDR_W{1'b0}})) begin
            val = {DATA_W{1'b0}};
        end else begin
            val = r_regs[addr];
        end
        return val;
    endfunction

    assign w_wr_en = we3 && (a3 != {ADDR_W{1'b0}}) && !rst;

    // Storage: async clear on rst, otherwise write entry a3 when enabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= {DATA_W{1'b0}};
            end
        end else if (w_wr_en) begin
            r_regs[a3] <= wd3;
        end
    end

    // Combinational read ports, with optional write-first forwarding on rd1/rd2.
    always_comb begin
        w_rd1 = {DATA_W{1'b0}};
        w_rd2 = {DATA_W{1'b0}};
        w_dbg = {DATA_W{1'b0}};
`ifdef REGFILE_BYPASS_EN
        // w_wr_en already excludes rst and a3==0, so forwarding never leaks
        // a value during reset or onto register 0.
        if (w_wr_en && (a3 == a1)) begin
            w_rd1 = wd3;
        end else begin
            w_rd1 = read_entry(a1);
        end
        if (w_wr_en && (a3 == a2)) begin
            w_rd2 = wd3;
        end else begin
            w_rd2 = read_entry(a2);
        end
`else
        w_rd1 = read_entry(a1);
        w_rd2 = read_entry(a2);
`endif
        // The debug port always shows committed state only.
        w_dbg = read_entry(dbg_addr);
    end

    assign rd1      = w_rd1;
    assign rd2      = w_rd2;
    assign dbg_data = w_dbg;

endmodule

// File: tb/tb_reg_file.sv
// -----------------------------------------------------------------------------
// tb_reg_file -- self-checking bench for reg_file
//
// A plain array holds the architectural register state. Expected read values
// come from that array plus the reset and forwarding rules. Inputs change at
// negedge+1; the compare process samples the outputs at negedge+3, which is
// well clear of the rising edge.
// -----------------------------------------------------------------------------
module tb_reg_file;

    localparam int DW = 32;
    localparam int AW = 5;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          we3 = 1'b0;
    logic [AW-1:0] a3 = '0;
    logic [DW-1:0] wd3 = '0;
    logic [AW-1:0] a1 = '0;
    logic [AW-1:0] a2 = '0;
    logic [AW-1:0] dbg_addr = '0;
    logic [DW-1:0] rd1;
    logic [DW-1:0] rd2;
    logic [DW-1:0] dbg_data;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    logic [DW-1:0] model [32];

    reg_file #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk      (clk),
        .rst      (rst),
        .we3      (we3),
        .a3       (a3),
        .wd3      (wd3),
        .a1       (a1),
        .a2       (a2),
        .rd1      (rd1),
        .rd2      (rd2),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 32; i++) model[i] = '0;
    end

    // Reference state: cleared the instant reset rises.
    always @(posedge rst) begin
        for (int i = 0; i < 32; i++) model[i] <= '0;
    end

    // Reference state: a write lands on the edge unless reset or register 0.
    always @(posedge clk) begin
        if (!rst && we3 && (a3 != 5'd0)) model[a3] <= wd3;
    end

    function automatic logic [DW-1:0] expect_read(input logic [AW-1:0] addr, input bit fwd);
        if (rst) return 32'd0;
        if (BYPASS && fwd && we3 && (a3 != 5'd0) && (a3 == addr)) return wd3;
        if (addr == 5'd0) return 32'd0;
        return model[addr];
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Compare process: every cycle, all three outputs against the reference.
    initial begin
        forever begin
            @(negedge clk);
            #3;
            if (chk_en) begin
                chk("cmp_rd1", rd1, expect_read(a1, 1'b1));
                chk("cmp_rd2", rd2, expect_read(a2, 1'b1));
                chk("cmp_dbg", dbg_data, expect_read(dbg_addr, 1'b0));
            end
        end
    end

    // Move to negedge+1, the point where inputs are changed.
    task automatic next_slot();
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input logic w, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                         input logic [AW-1:0] ra1, input logic [AW-1:0] ra2,
                         input logic [AW-1:0] da);
        we3 = w; a3 = wa; wd3 = wd; a1 = ra1; a2 = ra2; dbg_addr = da;
    endtask

    initial begin
        logic [AW-1:0] ra;
        chk_en = 1'b1;

        // 1: reset, release at 10ns, sweep a1 over every address.
        #10;
        rst = 1'b0;
        for (int i = 0; i < 32; i++) begin
            next_slot();
            drive(1'b0, 5'd0, 32'd0, AW'(i), AW'(31 - i), AW'(i));
            #2;
            chk("reset_sweep_rd1", rd1, 32'd0);
        end

        // 2: write 5, read on all ports.
        next_slot();
        drive(1'b1, 5'd5, 32'hDEADBEEF, 5'd1, 5'd2, 5'd3);
        next_slot();
        drive(1'b0, 5'd0, 32'd0, 5'd5, 5'd5, 5'd5);
        #2;
        chk("wr5_rd1", rd1, 32'hDEADBEEF);
        chk("wr5_rd2", rd2, 32'hDEADBEEF);
        chk("wr5_dbg", dbg_data, 32'hDEADBEEF);

        // 3: write to register 0 is ignored.
        next_slot();
        drive(1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd5, 5'd0);
        next_slot();
        drive(1'b0, 5'd0, 32'd0, 5'd0, 5'd5, 5'd0);
        #2;
        chk("zero_rd1", rd1, 32'd0);
        chk("zero_rd2_r5", rd2, 32'hDEADBEEF);
        chk("zero_dbg", dbg_data, 32'd0);
        for (int i = 1; i < 32; i++) begin
            next_slot();
            drive(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, AW'(i));
            #2;
            chk("zero_other", dbg_data, (i == 5) ? 32'hDEADBEEF : 32'd0);
        end

        // 4: same-cycle read-after-write.
        next_slot();
        drive(1'b1, 5'd7, 32'h11111111, 5'd0, 5'd0, 5'd0);
        next_slot();
        drive(1'b1, 5'd7, 32'h22222222, 5'd7, 5'd7, 5'd7);
        #2;
        chk("raw_before_rd1", rd1, BYPASS ? 32'h22222222 : 32'h11111111);
        chk("raw_before_dbg", dbg_data, 32'h11111111);
        next_slot();
        drive(1'b0, 5'd0, 32'd0, 5'd7, 5'd7, 5'd7);
        #2;
        chk("raw_after_rd1", rd1, 32'h22222222);

        // 5: fill 1..31 with index, then reset between edges.
        for (int i = 1; i < 32; i++) begin
            next_slot();
            drive(1'b1, AW'(i), DW'(i), 5'd0, 5'd0, 5'd0);
        end
        next_slot();
        drive(1'b0, 5'd0, 32'd0, 5'd17, 5'd31, 5'd3);
        #2;
        chk("fill_rd1", rd1, 32'd17);
        chk("fill_rd2", rd2, 32'd31);
        chk("fill_dbg", dbg_data, 32'd3);
        next_slot();
        drive(1'b0, 5'd0, 32'd0, 5'd17, 5'd31, 5'd3);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_rd1", rd1, 32'd0);
        chk("midrst_rd2", rd2, 32'd0);
        chk("midrst_dbg", dbg_data, 32'd0);
        next_slot();
        drive(1'b1, 5'd9, 32'hAAAAAAAA, 5'd9, 5'd9, 5'd9);
        #2;
        chk("rst_wr_rd1", rd1, 32'd0);
        next_slot();
        rst = 1'b0;
        drive(1'b0, 5'd0, 32'd0, 5'd9, 5'd17, 5'd9);
        #2;
        chk("rst_drop_rd1", rd1, 32'd0);
        chk("rst_drop_rd2", rd2, 32'd0);
        chk("rst_drop_dbg", dbg_data, 32'd0);

        // 6: random traffic against the reference array.
        for (int n = 0; n < 1000; n++) begin
            next_slot();
            we3 = ($urandom_range(0, 1) == 1);
            a3  = AW'($urandom_range(0, 31));
            wd3 = $urandom;
            ra  = AW'($urandom_range(0, 31));
            a1  = ($urandom_range(0, 3) == 0) ? a3 : ra;
            a2  = ($urandom_range(0, 3) == 0) ? a3 : AW'($urandom_range(0, 31));
            dbg_addr = ($urandom_range(0, 3) == 0) ? a3 : AW'($urandom_range(0, 31));
        end

        next_slot();
        drive(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 5'd0);
        #3;
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
